// File: rtl/if_stage.sv
// Fetch stage: issues I-RAM reads from fetch_pc, buffers {inst, pc, adef} in a 2-entry FIFO for ID.
// Latency: issue N, rdata N+1, right_valid N+2; backpressure via issue credit (count + inflight - pop < 2).
// Optional macro IF_ADEF_CHECK_EN: misaligned fetch PCs deliver adef=1 with a zeroed instruction.
`timescale 1ns/1ps
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_ram_en,
  output logic [31:0] inst_ram_addr,
  input  logic [31:0] inst_ram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] Inst,
  output logic [31:0] PC,
  output logic        excp_adef,
  output logic        right_valid,
  input  logic        right_ready
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adef;
  } entry_t;

  entry_t      ent0, ent1, new_ent;
  logic [1:0]  count;
  logic [31:0] fetch_pc, inflight_pc, target;
  logic        inflight, inflight_discard;
  logic        pop, push, issue, redirect;
  logic [2:0]  occ;

  always_comb begin
    pop      = right_valid & right_ready;
    redirect = flush | br_taken;
    target   = flush ? flush_pc : br_target;
    occ      = {1'b0, count} + {2'b00, inflight};
    // Gating with reset keeps the RAM quiet while reset is held.
    issue    = reset & ~redirect & (occ < (3'd2 + {2'b00, pop}));
    push     = inflight & ~inflight_discard & ~redirect;
    new_ent.pc = inflight_pc;
`ifdef IF_ADEF_CHECK_EN
    new_ent.adef = |inflight_pc[1:0];
    new_ent.inst = new_ent.adef ? 32'h0 : inst_ram_rdata;
`else
    new_ent.adef = 1'b0;
    new_ent.inst = inst_ram_rdata;
`endif
  end

  assign inst_ram_en   = issue;
  assign inst_ram_addr = {fetch_pc[31:2], 2'b00};
  assign right_valid   = (count != 2'd0);
  assign Inst          = ent0.inst;
  assign PC            = ent0.pc;
  assign excp_adef     = ent0.adef;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc         <= RESET_PC;
      inflight         <= 1'b0;
      inflight_pc      <= 32'h0;
      inflight_discard <= 1'b0;
      count            <= 2'd0;
      ent0             <= '0;
      ent1             <= '0;
    end else begin
      inflight         <= issue;
      // A redirect poisons anything still outstanding from before it.
      inflight_discard <= redirect;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (redirect) begin
        fetch_pc <= target;
      end

      if (redirect) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) ent0 <= new_ent;
            else               ent1 <= new_ent;
            count <= count + 2'd1;
          end
          2'b01: begin
            ent0  <= ent1;
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              ent0 <= new_ent;
            end else begin
              ent0 <= ent1;
              ent1 <= new_ent;
            end
          end
          default: ;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a program-order PC stream model and a hashed I-RAM.
`timescale 1ns/1ps
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_ram_en;
  logic [31:0] inst_ram_addr;
  logic [31:0] inst_ram_rdata = 32'h0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic [31:0] Inst, PC;
  logic        excp_adef, right_valid;
  logic        right_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .inst_ram_en(inst_ram_en), .inst_ram_addr(inst_ram_addr), .inst_ram_rdata(inst_ram_rdata),
    .br_taken(br_taken), .br_target(br_target), .flush(flush), .flush_pc(flush_pc),
    .Inst(Inst), .PC(PC), .excp_adef(excp_adef),
    .right_valid(right_valid), .right_ready(right_ready)
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) if (inst_ram_en) inst_ram_rdata <= ram_word(inst_ram_addr);

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
`ifdef IF_ADEF_CHECK_EN
    if (pc[1:0] != 2'b00) return 32'h0;
`endif
    return ram_word({pc[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] exp_adef(input logic [31:0] pc);
`ifdef IF_ADEF_CHECK_EN
    return {31'h0, (pc[1:0] != 2'b00)};
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 19) == 0) return 32'hFFFFFFF8;
    p = RESET_PC + ($urandom_range(0, 1023) << 2);
    if ($urandom_range(0, 3) == 0) p = p + $urandom_range(1, 3);
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accepted PCs follow program order, restarting at each redirect target.
  initial begin
    logic [31:0] exp_pc, hold_pc, hold_inst;
    int          since;
    logic        hold;
    exp_pc = RESET_PC; since = 0; hold = 1'b0; hold_pc = 0; hold_inst = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_pc = RESET_PC; since = 0; hold = 1'b0;
      end else begin
        if (since < 100) since++;
        if (since == 1 || since == 2) check("blank_after_restart", right_valid, 0);
        if (since == 3) check("refill_valid", right_valid, 1);
        if (hold) begin
          check("hold_valid", right_valid, 1);
          check("hold_pc", PC, hold_pc);
          check("hold_inst", Inst, hold_inst);
        end
        if (inst_ram_en) check("addr_align", inst_ram_addr[1:0], 0);
        if (right_valid && right_ready) begin
          check("out_pc", PC, exp_pc);
          check("out_inst", Inst, exp_inst(exp_pc));
          check("out_adef", excp_adef, exp_adef(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
        hold      = right_valid && !right_ready && !(flush || br_taken);
        hold_pc   = PC;
        hold_inst = Inst;
        if (flush || br_taken) begin
          exp_pc = flush ? flush_pc : br_target;
          since  = 0;
        end
      end
    end
  end

  initial begin
    int r;
    repeat (2) step();
    check("rst_valid", right_valid, 0);
    check("rst_en", inst_ram_en, 0);
    check("rst_addr", inst_ram_addr, RESET_PC);
    check("rst_inst", Inst, 0);
    check("rst_pc", PC, 0);
    check("rst_adef", excp_adef, 0);

    step(); reset = 1'b1; right_ready = 1'b1;
    #1 check("first_en", inst_ram_en, 1);
    check("first_addr", inst_ram_addr, RESET_PC);
    step();
    check("second_addr", inst_ram_addr, RESET_PC + 32'd4);
    check("second_valid", right_valid, 0);
    step();
    check("third_valid", right_valid, 1);
    check("third_pc", PC, RESET_PC);
    repeat (10) begin step(); check("stream_valid", right_valid, 1); end

    right_ready = 1'b0;
    repeat (4) begin
      #1 check("stall_no_issue", inst_ram_en, 0);
      check("stall_valid", right_valid, 1);
      step();
    end
    right_ready = 1'b1;
    repeat (8) begin #1 check("release_valid", right_valid, 1); step(); end

    right_ready = 1'b0;
    step(); step();
    br_taken = 1'b1; br_target = 32'h1c000100;
    step();
    br_taken = 1'b0; right_ready = 1'b1;
    step(); step();
    check("branch_pc", PC, 32'h1c000100);
    repeat (4) step();

    flush = 1'b1; flush_pc = 32'h1c000800; br_taken = 1'b1; br_target = 32'h1c000100;
    step();
    flush = 1'b0; br_taken = 1'b0;
    step(); step();
    check("flush_priority_pc", PC, 32'h1c000800);
    repeat (4) step();

    br_taken = 1'b1; br_target = 32'h1c000102;
    step();
    br_taken = 1'b0;
    step(); step();
    check("misalign_pc", PC, 32'h1c000102);
`ifdef IF_ADEF_CHECK_EN
    check("misalign_adef", excp_adef, 1);
    check("misalign_inst", Inst, 0);
`else
    check("misalign_adef", excp_adef, 0);
    check("misalign_inst", Inst, ram_word(32'h1c000100));
`endif
    repeat (4) step();

    right_ready = 1'b0;
    repeat (4) step();
    #2 reset = 1'b0;
    #1 check("midrst_valid", right_valid, 0);
    check("midrst_en", inst_ram_en, 0);
    check("midrst_pc", PC, 0);
    check("midrst_inst", Inst, 0);
    step(); reset = 1'b1; right_ready = 1'b1;
    #1 check("restart_addr", inst_ram_addr, RESET_PC);
    check("restart_en", inst_ram_en, 1);
    step(); step();
    check("restart_pc", PC, RESET_PC);

    repeat (3000) begin
      step();
      right_ready = ($urandom_range(0, 3) != 0);
      r           = $urandom_range(0, 15);
      br_taken    = (r == 0) || (r == 1);
      flush       = (r == 1) || (r == 2);
      br_target   = rand_pc();
      flush_pc    = rand_pc();
    end
    step();
    br_taken = 1'b0; flush = 1'b0; right_ready = 1'b1;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
